nios2_button_pio: RTL and testbench
===================================

NIOS2_BUTTON_PIO -- requirements
Module: nios2_button_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of input lines (legal range 1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable-time qualification in clk cycles (legal minimum 1).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: port clk (all state on rising edge) and port reset_n (asynchronous, active-low).
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port address, input, 2: Avalon-MM slave word address.
REQ-007 Port chipselect, input, 1: slave select.
REQ-008 Port write_n, input, 1: active-low write strobe.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port in_port, input, WIDTH: asynchronous active-low button lines (idle high).
REQ-011 Port readdata, output, 32: read data, zero wait states, combinational from registers.
REQ-012 Port irq, output, 1: active-high level interrupt.

Function
REQ-013 Register map SHALL be:
- 0 = DATA (RO, debounced value)
- 1 = reserved (reads 0, writes ignored)
- 2 = IRQMASK (RW, WIDTH bits)
- 3 = EDGECAPTURE (read; write-1-to-clear per bit)
REQ-014 readdata SHALL be the selected register zero-extended to 32 bits, independent of chipselect; bits [31:WIDTH] SHALL be 0.
REQ-015 A write SHALL occur when chipselect=1 and write_n=0 on a rising edge; writes to address 0 or 1 SHALL have no effect.
REQ-016 Each in_port bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-017 Each bit SHALL have a debounce counter of width clog2(DEBOUNCE_CYCLES), max 1, and a stable flop.
REQ-018 Debounce rules per bit, per edge:
- sync2 == stable: counter <= 0.
- sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
- sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL reset the counter and never change stable.
REQ-020 Latency SHALL be as follows: for an in_port change held steady and first sampled at edge 0, stable updates at edge DEBOUNCE_CYCLES+1.
REQ-021 DATA SHALL equal the stable vector.
REQ-022 EDGECAPTURE[i] SHALL set on the same edge stable[i] transitions 1->0; rising transitions SHALL NOT set it.
REQ-023 A set EDGECAPTURE bit SHALL stay set until cleared by writing 1 to that bit at address 3; writing 0 SHALL leave the bit unchanged.
REQ-024 If a clearing write and a new falling edge hit the same bit on the same edge, set SHALL win (bit = 1).
REQ-025 irq SHALL equal OR-reduction of (EDGECAPTURE & IRQMASK), combinational.
REQ-026 irq SHALL deassert the cycle after clear or mask write.
REQ-027 IRQMASK writes SHALL NOT alter EDGECAPTURE; unmasked edges SHALL still be captured.

Reset
REQ-028 While reset_n=0, sync1, sync2 and stable SHALL be all ones, counters 0, IRQMASK 0, EDGECAPTURE 0, irq 0; DATA SHALL read {WIDTH{1}}.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count.
REQ-030 After reset_n rises, an in_port bit already low SHALL be qualified normally and SHALL produce one EDGECAPTURE set.

Verification (bench: WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-031 Reset then idle: in_port=4'hF -> DATA=0x0000000F, EDGECAPTURE=0, irq=0 for 100 cycles.
REQ-032 Press bit 1: in_port=4'hD held; sampled edge 0 -> DATA=0xD and EDGECAPTURE=0x2 at edge 5, not earlier; with IRQMASK=0x2, irq=1 after edge 5.
REQ-033 Glitch: in_port bit 0 low for 3 cycles then high -> DATA stays 0xF, EDGECAPTURE stays 0, irq stays 0.
REQ-034 Clear, then release: EDGECAPTURE=0x2, write 0x2 to address 3 -> EDGECAPTURE=0 and irq=0 next cycle; release to 4'hF -> DATA=0xF with no new capture.
REQ-035 Clear/edge collision: write 0x1 to address 3 on the same edge bit 0 qualifies low -> EDGECAPTURE[0]=1.
REQ-036 Mask/reserved: IRQMASK=0, press bit 3 -> EDGECAPTURE=0x8, irq=0; write 0x8 to IRQMASK -> irq=1; write to address 1 -> no register changes, readback at address 1 = 0.

Source files
------------

// File: rtl/nios2_button_pio.sv
// Avalon-MM button PIO: per-bit sync + debounce, falling-edge capture with write-1-to-clear,
// maskable level interrupt.
module nios2_button_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] clr, fall;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Counter runs only while the synchronized input disagrees with the stable value.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    fall   = stable_q & ~stable_d;
    clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // A new falling edge wins over a simultaneous clear.
    edge_d = (edge_q & ~clr) | fall;
    mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      mask_q   <= '0;
      edge_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable_q;
      2'd2:    readdata[WIDTH-1:0] = mask_q;
      2'd3:    readdata[WIDTH-1:0] = edge_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios2_button_pio.sv
// Directed bench for nios2_button_pio with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_nios2_button_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  nios2_button_pio #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  // Presents a write for exactly one rising edge; returns 1 ns after that edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // Reset state
    cycles(3);
    chk_reg("rst_data", 2'd0, 32'h0000_000F);
    chk_reg("rst_mask", 2'd2, 32'h0);
    chk_reg("rst_edge", 2'd3, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;

    // Idle for 100 cycles
    for (int k = 0; k < 100; k++) begin
      cycles(1);
      check("idle_irq", {31'b0, irq}, 32'h0);
    end
    chk_reg("idle_data", 2'd0, 32'h0000_000F);
    chk_reg("idle_edge", 2'd3, 32'h0);

    // 3-cycle glitch on bit 0 must be rejected
    in_port = 4'hE;
    cycles(3);
    in_port = 4'hF;
    cycles(10);
    chk_reg("glitch_data", 2'd0, 32'h0000_000F);
    chk_reg("glitch_edge", 2'd3, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // Press bit 1 with mask 0x2: qualifies at edge 5, not before
    wr(2'd2, 32'h2);
    in_port = 4'hD;
    for (int k = 0; k <= 5; k++) begin
      cycles(1);
      if (k < 5) begin
        chk_reg("press_early_data", 2'd0, 32'h0000_000F);
        chk_reg("press_early_edge", 2'd3, 32'h0);
        check("press_early_irq", {31'b0, irq}, 32'h0);
      end else begin
        chk_reg("press_data", 2'd0, 32'h0000_000D);
        chk_reg("press_edge", 2'd3, 32'h2);
        check("press_irq", {31'b0, irq}, 32'h1);
      end
    end

    // Write 0 leaves the bit, write 1 clears it
    wr(2'd3, 32'h0);
    chk_reg("w0_edge", 2'd3, 32'h2);
    wr(2'd3, 32'h2);
    chk_reg("clr_edge", 2'd3, 32'h0);
    check("clr_irq", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    cycles(8);
    chk_reg("release_data", 2'd0, 32'h0000_000F);
    chk_reg("release_edge", 2'd3, 32'h0);

    // Clear and new falling edge on bit 0 at the same edge: set wins
    in_port = 4'hE;
    cycles(5);
    wr(2'd3, 32'h1);
    chk_reg("coll_data", 2'd0, 32'h0000_000E);
    chk_reg("coll_edge", 2'd3, 32'h1);
    check("coll_irq", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'h1);
    chk_reg("coll_clr", 2'd3, 32'h0);
    in_port = 4'hF;
    cycles(8);

    // Masked capture, then unmask; reserved and DATA writes ignored
    wr(2'd2, 32'h0);
    in_port = 4'h7;
    cycles(8);
    chk_reg("mask_edge", 2'd3, 32'h8);
    check("masked_irq", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h8);
    check("unmask_irq", {31'b0, irq}, 32'h1);
    chk_reg("unmask_edge", 2'd3, 32'h8);
    wr(2'd1, 32'hFFFF_FFFF);
    chk_reg("resv_read", 2'd1, 32'h0);
    chk_reg("resv_mask", 2'd2, 32'h8);
    chk_reg("resv_edge", 2'd3, 32'h8);
    wr(2'd0, 32'h0);
    chk_reg("ro_data", 2'd0, 32'h0000_0007);
    wr(2'd2, 32'hFFFF_FFFF);
    chk_reg("mask_zext", 2'd2, 32'h0000_000F);
    check("mask_all_irq", {31'b0, irq}, 32'h1);

    // Reset mid-debounce of bit 2, then lines already low get qualified after release
    in_port = 4'h3;
    cycles(3);
    reset_n = 1'b0;
    #1;
    chk_reg("midrst_data", 2'd0, 32'h0000_000F);
    chk_reg("midrst_edge", 2'd3, 32'h0);
    chk_reg("midrst_mask", 2'd2, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    cycles(2);
    reset_n = 1'b1;
    cycles(5);
    chk_reg("post_rst_early", 2'd0, 32'h0000_000F);
    cycles(1);
    chk_reg("post_rst_data", 2'd0, 32'h0000_0003);
    chk_reg("post_rst_edge", 2'd3, 32'h0000_000C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
